// File: rtl/digdug_hs_pkg.sv
// Shared types and default parameters for the Dig Dug hiscore transfer engine.
// The state encoding is visible to checkers through the interface debug signal.
package digdug_hs_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_RD_LAT = 2;
  localparam int DEF_SETTLE = 16;

  // One counter width covers both the settle delay (up to 255) and read latency.
  localparam int CTR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_OUT  = 3'd4,
    ST_WR_IN   = 3'd5,
    ST_WR_STB  = 3'd6,
    ST_FINISH  = 3'd7
  } hs_state_e;

endpackage

// File: rtl/hiscore_xfer_if.sv
// Command, host byte streams and game-side RAM port of the hiscore transfer engine.
// Streams: a byte moves on the rising edge where VALID and READY are both 1; the
// source holds VALID and DATA stable until then, and READY may change freely.
interface hiscore_xfer_if #(
  parameter int ADDR_W = digdug_hs_pkg::DEF_ADDR_W
);
  logic              CMD_START;
  logic              CMD_DIR;
  logic [ADDR_W-1:0] CMD_BASE;
  logic [ADDR_W-1:0] CMD_LEN;
  logic              ABORT;
  logic              BUSY;
  logic              DONE;
  logic              ABORTED;
  logic              PAUSE_REQ;
  logic [7:0]        SI_DATA;
  logic              SI_VALID;
  logic              SI_READY;
  logic [7:0]        SO_DATA;
  logic              SO_VALID;
  logic              SO_READY;
  logic [ADDR_W-1:0] hs_address;
  logic [7:0]        hs_data_in;
  logic [7:0]        hs_data_out;
  logic              hs_write;
  logic              hs_access;
  digdug_hs_pkg::hs_state_e state_dbg;

  modport slave (
    input  CMD_START, CMD_DIR, CMD_BASE, CMD_LEN, ABORT,
    input  SI_DATA, SI_VALID, SO_READY, hs_data_out,
    output BUSY, DONE, ABORTED, PAUSE_REQ, SI_READY, SO_DATA, SO_VALID,
    output hs_address, hs_data_in, hs_write, hs_access, state_dbg
  );

  modport master (
    output CMD_START, CMD_DIR, CMD_BASE, CMD_LEN, ABORT,
    output SI_DATA, SI_VALID, SO_READY, hs_data_out,
    input  BUSY, DONE, ABORTED, PAUSE_REQ, SI_READY, SO_DATA, SO_VALID,
    input  hs_address, hs_data_in, hs_write, hs_access, state_dbg
  );

endinterface

// File: rtl/hs_delay_ctr.sv
// Loadable down-counter that stops at zero; times both the CPU settle delay
// and the RAM read latency of the hiscore transfer engine.
module hs_delay_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/hiscore_xfer.sv
// Moves hiscore bytes between the game RAM and a host byte stream while the
// game CPUs are paused; save streams RAM out, load writes host bytes into RAM.
module hiscore_xfer
  import digdug_hs_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic MCLK,
  input  logic RESET,
  hiscore_xfer_if.slave bus
);

  // Counter runs from N-1 down to 0, giving exactly N cycles in the timed state.
  localparam logic [CTR_W-1:0] SETTLE_LD = CTR_W'(SETTLE - 1);
  localparam logic [CTR_W-1:0] RD_LAT_LD = CTR_W'(RD_LAT - 1);

  hs_state_e         state_q, state_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              aborted_q, aborted_d;
  logic              ctr_load, ctr_en, ctr_zero;
  logic [CTR_W-1:0]  ctr_val;
  logic              last_byte;
  logic [ADDR_W-1:0] idx_inc;

  assign last_byte = (idx_q == len_q);
  assign idx_inc   = idx_q + ADDR_W'(1);

  hs_delay_ctr #(.W(CTR_W)) u_delay (
    .clk_i      (MCLK),
    .rst_i      (RESET),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .en_i       (ctr_en),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aborted_d = 1'b0;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    ctr_val   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.CMD_START) begin
          dir_d    = bus.CMD_DIR;
          base_d   = bus.CMD_BASE;
          len_d    = bus.CMD_LEN;
          idx_d    = '0;
          ctr_load = 1'b1;
          ctr_val  = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        ctr_en = 1'b1;
        if (ctr_zero) begin
          addr_d  = base_q;
          state_d = dir_q ? ST_WR_IN : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        ctr_load = 1'b1;
        ctr_val  = RD_LAT_LD;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        ctr_en = 1'b1;
        if (ctr_zero) begin
          rdata_d = bus.hs_data_out;
          state_d = ST_RD_OUT;
        end
      end
      ST_RD_OUT: begin
        if (bus.SO_READY) begin
          if (last_byte) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_inc;
            addr_d  = base_q + idx_inc;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WR_IN: begin
        if (bus.SI_VALID) begin
          wdata_d = bus.SI_DATA;
          state_d = ST_WR_STB;
        end
      end
      ST_WR_STB: begin
        // Address moves only on the edge that ends the strobe.
        if (last_byte) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_inc;
          addr_d  = base_q + idx_inc;
          state_d = ST_WR_IN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any handshake decoded above, so that byte is dropped.
    if ((state_q != ST_IDLE) && bus.ABORT) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end

    if (state_d == ST_IDLE) begin
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.PAUSE_REQ  = (state_q != ST_IDLE);
  assign bus.hs_access  = (state_q != ST_IDLE) && (state_q != ST_SETTLE);
  assign bus.DONE       = (state_q == ST_FINISH);
  assign bus.ABORTED    = aborted_q;
  assign bus.SO_VALID   = (state_q == ST_RD_OUT);
  assign bus.SI_READY   = (state_q == ST_WR_IN);
  assign bus.hs_write   = (state_q == ST_WR_STB);
  assign bus.hs_address = addr_q;
  assign bus.hs_data_in = wdata_q;
  assign bus.SO_DATA    = rdata_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_hiscore_xfer.sv
// Randomized bench for hiscore_xfer: a latency-accurate RAM model on the game side
// and a plain array reference of what the RAM should hold after every command.
module tb_hiscore_xfer;
  import digdug_hs_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int RL    = DEF_RD_LAT;
  localparam int ST    = DEF_SETTLE;
  localparam int RAM_N = 1 << AW;
  localparam int LOG_N = 8192;
  localparam int OW    = 7 + AW + 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hiscore_xfer_if #(.ADDR_W(AW)) bus ();

  hiscore_xfer #(.ADDR_W(AW), .RD_LAT(RL), .SETTLE(ST)) dut (
    .MCLK  (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Game RAM: written by the DUT strobe or a bulk preload, read with RL cycles latency.
  logic [7:0]    ram      [RAM_N];
  logic [7:0]    fill_src [RAM_N];
  logic [7:0]    ref_mem  [RAM_N];
  logic          fill_en = 1'b0;
  logic [7:0]    rd_pipe  [RL];
  int            wr_cnt   = 0;
  int            prot_err = 0;
  logic [AW-1:0] wr_addr_log [LOG_N];
  logic [7:0]    wr_data_log [LOG_N];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= fill_src[i];
    end else if (bus.hs_write) begin
      ram[bus.hs_address]       <= bus.hs_data_in;
      wr_addr_log[wr_cnt % LOG_N] <= bus.hs_address;
      wr_data_log[wr_cnt % LOG_N] <= bus.hs_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    prot_err <= prot_err + int'(bus.hs_write && !bus.hs_access) + int'(bus.SI_READY && bus.SO_VALID);
    rd_pipe[0] <= ram[bus.hs_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.hs_data_out = rd_pipe[RL-1];

  logic [7:0] so_got [$];
  logic [7:0] si_src [$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] pack_outs();
    return {bus.BUSY, bus.DONE, bus.PAUSE_REQ, bus.SI_READY, bus.SO_VALID, bus.hs_write,
            bus.hs_access, bus.hs_address, bus.hs_data_in, bus.SO_DATA};
  endfunction

  task automatic start_cmd(input logic dir, input logic [AW-1:0] base, input logic [AW-1:0] len);
    bus.CMD_DIR   = dir;
    bus.CMD_BASE  = base;
    bus.CMD_LEN   = len;
    bus.CMD_START = 1'b1;
    tick();
    bus.CMD_START = 1'b0;
  endtask

  task automatic recover(input bit timed_out);
    if (timed_out) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  // mode 0: ready always, 1: random ready, 2: ready held low 10 cycles at first valid
  task automatic do_save(input logic [AW-1:0] base, input logic [AW-1:0] len, input int mode,
                         output int done_n, output int abort_n, output int pause_at,
                         output int first_acc, output int bp_viol, output bit timed_out);
    int c, budget, hold;
    bit seen;
    logic [7:0] held_d;
    logic [AW-1:0] held_a;
    so_got.delete();
    done_n = 0; abort_n = 0; pause_at = -1; first_acc = -1; bp_viol = 0; timed_out = 0;
    hold = 0; seen = 0; held_d = '0; held_a = '0;
    budget = ST + 20 + (int'(len) + 1) * (RL + 30);
    start_cmd(1'b0, base, len);
    c = 1;
    while (bus.BUSY) begin
      if (c > budget) begin timed_out = 1; break; end
      if (bus.DONE) done_n++;
      if (bus.ABORTED) abort_n++;
      if (bus.PAUSE_REQ && pause_at < 0) pause_at = c;
      if (bus.hs_access && first_acc < 0) first_acc = c;
      if (mode == 0) bus.SO_READY = 1'b1;
      else if (mode == 1) bus.SO_READY = 1'($urandom_range(0, 1));
      else begin
        if (bus.SO_VALID && !seen) begin
          seen = 1; hold = 10; held_d = bus.SO_DATA; held_a = bus.hs_address;
        end
        if (hold > 0) begin
          if (!bus.SO_VALID || bus.SO_DATA !== held_d || bus.hs_address !== held_a) bp_viol++;
          hold--;
          bus.SO_READY = 1'b0;
        end else bus.SO_READY = 1'b1;
      end
      if (bus.SO_VALID && bus.SO_READY) so_got.push_back(bus.SO_DATA);
      tick();
      c++;
    end
    if (bus.DONE) done_n++;
    if (bus.ABORTED) abort_n++;
    bus.SO_READY = 1'b0;
    recover(timed_out);
  endtask

  // valid_mode 0: always valid, 1: random; abort_at = handshake index to abort on (-1 none)
  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input int valid_mode,
                         input int abort_at, input int poke_c,
                         output int done_n, output int abort_n, output int n_hs,
                         output logic [OW-1:0] post_abort, output bit timed_out);
    int c, budget, k;
    bit abort_now;
    done_n = 0; abort_n = 0; k = 0; timed_out = 0; post_abort = '1;
    budget = ST + 20 + (int'(len) + 1) * 20;
    start_cmd(1'b1, base, len);
    c = 1;
    while (bus.BUSY) begin
      if (c > budget) begin timed_out = 1; break; end
      if (bus.DONE) done_n++;
      if (bus.ABORTED) abort_n++;
      bus.SI_VALID = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.SI_DATA  = (k < si_src.size()) ? si_src[k] : 8'($urandom);
      abort_now = 0;
      if (bus.SI_VALID && bus.SI_READY) begin
        if (k == abort_at) abort_now = 1;
        else k++;
      end
      if (c == poke_c) begin
        bus.CMD_START = 1'b1; bus.CMD_DIR = 1'b0;
        bus.CMD_BASE = ~base; bus.CMD_LEN = len + AW'(5);
      end
      bus.ABORT = abort_now;
      tick();
      c++;
      bus.ABORT = 1'b0;
      bus.CMD_START = 1'b0;
      if (abort_now) post_abort = pack_outs();
    end
    if (bus.DONE) done_n++;
    if (bus.ABORTED) abort_n++;
    bus.SI_VALID = 1'b0;
    n_hs = k;
    recover(timed_out);
  endtask

  task automatic init_ram();
    for (int i = 0; i < RAM_N; i++) begin
      fill_src[i] = 8'($urandom);
      ref_mem[i]  = fill_src[i];
    end
    fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (pack_outs() !== '0) begin
      bad++; $display("FAIL reset_outs: got %h expected 0", pack_outs());
    end
    total++;
    if (bus.ABORTED !== 1'b0) begin
      bad++; $display("FAIL reset_aborted: got %b expected 0", bus.ABORTED);
    end
    rst = 1'b0;
    tick();
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    total++;
    if (bus.ABORTED !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL idle_abort: aborted=%b busy=%b expected 0 0", bus.ABORTED, bus.BUSY);
    end
  endtask

  task automatic test_save_basic();
    int dn, an, pa, fa, bv; bit to;
    do_save(AW'(11'h3F0), AW'(3), 0, dn, an, pa, fa, bv, to);
    total++;
    if (to) begin bad++; $display("FAIL save_basic_timeout: got timeout expected completion"); end
    total++;
    if (pa !== 1) begin bad++; $display("FAIL save_pause_rise: got cycle %0d expected 1", pa); end
    total++;
    if (fa !== ST + 1) begin bad++; $display("FAIL save_first_access: got cycle %0d expected %0d", fa, ST + 1); end
    total++;
    if (so_got.size() !== 4) begin bad++; $display("FAIL save_count: got %0d expected 4", so_got.size()); end
    for (int i = 0; i < 4 && i < so_got.size(); i++) begin
      total++;
      if (so_got[i] !== ref_mem[(11'h3F0 + i) % RAM_N]) begin
        bad++; $display("FAIL save_byte[%0d]: got %02h expected %02h", i, so_got[i], ref_mem[(11'h3F0 + i) % RAM_N]);
      end
    end
    total++;
    if (dn !== 1 || an !== 0) begin bad++; $display("FAIL save_done: done=%0d aborted=%0d expected 1 0", dn, an); end
  endtask

  task automatic test_load_wrap();
    int dn, an, nh, w0, pa, fa, bv; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] exp_a;
    si_src = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    w0 = wr_cnt;
    do_load(AW'(11'h7FE), AW'(3), 0, -1, -1, dn, an, nh, pab, to);
    total++;
    if (wr_cnt - w0 !== 4) begin bad++; $display("FAIL wrap_write_count: got %0d expected 4", wr_cnt - w0); end
    for (int i = 0; i < 4 && i < wr_cnt - w0; i++) begin
      exp_a = AW'((11'h7FE + i) % RAM_N);
      total++;
      if (wr_addr_log[(w0 + i) % LOG_N] !== exp_a || wr_data_log[(w0 + i) % LOG_N] !== si_src[i]) begin
        bad++; $display("FAIL wrap_write[%0d]: got %h/%02h expected %h/%02h", i,
                        wr_addr_log[(w0 + i) % LOG_N], wr_data_log[(w0 + i) % LOG_N], exp_a, si_src[i]);
      end
    end
    total++;
    if (dn !== 1 || an !== 0 || to) begin bad++; $display("FAIL wrap_done: done=%0d aborted=%0d expected 1 0", dn, an); end
    for (int i = 0; i < 4; i++) ref_mem[(11'h7FE + i) % RAM_N] = si_src[i];
    do_save(AW'(11'h7FE), AW'(3), 1, dn, an, pa, fa, bv, to);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= so_got.size() || so_got[i] !== ref_mem[(11'h7FE + i) % RAM_N]) begin
        bad++; $display("FAIL wrap_readback[%0d]: got %02h expected %02h", i,
                        (i < so_got.size()) ? so_got[i] : 8'h00, ref_mem[(11'h7FE + i) % RAM_N]);
      end
    end
  endtask

  task automatic test_backpressure();
    int dn, an, pa, fa, bv; bit to;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    do_save(base, AW'(1), 2, dn, an, pa, fa, bv, to);
    total++;
    if (bv !== 0) begin bad++; $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bv); end
    total++;
    if (so_got.size() !== 2 || so_got[0] !== ref_mem[base] || so_got[1] !== ref_mem[(int'(base) + 1) % RAM_N]) begin
      bad++; $display("FAIL backpressure_bytes: got %0d bytes expected 2 matching %02h %02h",
                      so_got.size(), ref_mem[base], ref_mem[(int'(base) + 1) % RAM_N]);
    end
    total++;
    if (dn !== 1 || to) begin bad++; $display("FAIL backpressure_done: got %0d expected 1", dn); end
  endtask

  task automatic test_abort();
    int dn, an, nh, w0; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    si_src.delete();
    for (int i = 0; i < 4; i++) si_src.push_back(8'($urandom));
    w0 = wr_cnt;
    do_load(base, AW'(3), 0, 1, -1, dn, an, nh, pab, to);
    total++;
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL abort_write_count: got %0d expected 1", wr_cnt - w0); end
    total++;
    if (wr_addr_log[w0 % LOG_N] !== base || wr_data_log[w0 % LOG_N] !== si_src[0]) begin
      bad++; $display("FAIL abort_first_write: got %h/%02h expected %h/%02h",
                      wr_addr_log[w0 % LOG_N], wr_data_log[w0 % LOG_N], base, si_src[0]);
    end
    total++;
    if (an !== 1 || dn !== 0) begin bad++; $display("FAIL abort_pulses: aborted=%0d done=%0d expected 1 0", an, dn); end
    total++;
    if (pab !== '0) begin bad++; $display("FAIL abort_outs: got %h expected 0", pab); end
    ref_mem[base] = si_src[0];
  endtask

  task automatic test_busy_ignore();
    int dn, an, nh, w0, errs; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    si_src.delete();
    for (int i = 0; i < 3; i++) si_src.push_back(8'($urandom));
    w0 = wr_cnt;
    do_load(base, AW'(2), 1, -1, 5, dn, an, nh, pab, to);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      if (wr_addr_log[(w0 + i) % LOG_N] !== AW'((int'(base) + i) % RAM_N) ||
          wr_data_log[(w0 + i) % LOG_N] !== si_src[i]) errs++;
    end
    total++;
    if (wr_cnt - w0 !== 3 || errs !== 0) begin
      bad++; $display("FAIL busy_ignore_writes: got %0d writes %0d wrong expected 3 0", wr_cnt - w0, errs);
    end
    total++;
    if (dn !== 1 || to) begin bad++; $display("FAIL busy_ignore_done: got %0d expected 1", dn); end
    for (int i = 0; i < 3; i++) ref_mem[(int'(base) + i) % RAM_N] = si_src[i];
    repeat (3) tick();
    total++;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL busy_ignore_restart: got busy=%b expected 0", bus.BUSY); end
  endtask

  task automatic test_len_zero();
    int dn, an, nh, w0, pa, fa, bv; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    do_save(base, AW'(0), 1, dn, an, pa, fa, bv, to);
    total++;
    if (so_got.size() !== 1 || so_got[0] !== ref_mem[base] || dn !== 1) begin
      bad++; $display("FAIL len0_save: got %0d bytes done=%0d expected 1 byte %02h done=1", so_got.size(), dn, ref_mem[base]);
    end
    si_src = {8'($urandom)};
    w0 = wr_cnt;
    do_load(base, AW'(0), 1, -1, -1, dn, an, nh, pab, to);
    total++;
    if (wr_cnt - w0 !== 1 || wr_data_log[w0 % LOG_N] !== si_src[0] || dn !== 1) begin
      bad++; $display("FAIL len0_load: got %0d writes done=%0d expected 1 write done=1", wr_cnt - w0, dn);
    end
    ref_mem[base] = si_src[0];
  endtask

  task automatic test_reset_mid_save();
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    bus.SO_READY = 1'b1;
    start_cmd(1'b0, base, AW'(5));
    repeat (ST + 1) tick();
    total++;
    if (bus.state_dbg !== ST_RD_WAIT) begin
      bad++; $display("FAIL midreset_state: got %0d expected %0d", bus.state_dbg, ST_RD_WAIT);
    end
    bus.CMD_START = 1'b1;
    bus.ABORT = 1'b1;
    rst = 1'b1;
    tick();
    bus.CMD_START = 1'b0;
    bus.ABORT = 1'b0;
    total++;
    if (pack_outs() !== '0 || bus.ABORTED !== 1'b0) begin
      bad++; $display("FAIL midreset_outs: got %h aborted=%b expected 0 0", pack_outs(), bus.ABORTED);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ABORTED !== 1'b0) begin
      bad++; $display("FAIL midreset_after: busy=%b done=%b aborted=%b expected 0 0 0", bus.BUSY, bus.DONE, bus.ABORTED);
    end
    bus.SO_READY = 1'b0;
  endtask

  task automatic test_random();
    int dn, an, nh, w0, pa, fa, bv, errs, n; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] base, len;
    for (int it = 0; it < 10; it++) begin
      base = AW'($urandom_range(0, RAM_N - 1));
      len  = AW'($urandom_range(0, 12));
      n = int'(len) + 1;
      errs = 0;
      if ($urandom_range(0, 1) == 1) begin
        si_src.delete();
        for (int i = 0; i < n; i++) si_src.push_back(8'($urandom));
        w0 = wr_cnt;
        do_load(base, len, 1, -1, -1, dn, an, nh, pab, to);
        for (int i = 0; i < n; i++) begin
          if (wr_addr_log[(w0 + i) % LOG_N] !== AW'((int'(base) + i) % RAM_N) ||
              wr_data_log[(w0 + i) % LOG_N] !== si_src[i]) errs++;
          ref_mem[(int'(base) + i) % RAM_N] = si_src[i];
        end
        total++;
        if (wr_cnt - w0 !== n || errs !== 0 || dn !== 1) begin
          bad++; $display("FAIL rand_load[%0d]: writes=%0d wrong=%0d done=%0d expected %0d 0 1", it, wr_cnt - w0, errs, dn, n);
        end
      end else begin
        do_save(base, len, 1, dn, an, pa, fa, bv, to);
        for (int i = 0; i < n && i < so_got.size(); i++)
          if (so_got[i] !== ref_mem[(int'(base) + i) % RAM_N]) errs++;
        total++;
        if (so_got.size() !== n || errs !== 0 || dn !== 1) begin
          bad++; $display("FAIL rand_save[%0d]: bytes=%0d wrong=%0d done=%0d expected %0d 0 1", it, so_got.size(), errs, dn, n);
        end
      end
    end
  endtask

  task automatic test_full_ram();
    int dn, an, nh, w0, pa, fa, bv, errs; bit to;
    logic [OW-1:0] pab;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, RAM_N - 1));
    si_src.delete();
    for (int i = 0; i < RAM_N; i++) si_src.push_back(8'($urandom));
    w0 = wr_cnt;
    do_load(base, AW'(RAM_N - 1), 1, -1, -1, dn, an, nh, pab, to);
    errs = 0;
    for (int i = 0; i < RAM_N; i++) begin
      if (wr_addr_log[(w0 + i) % LOG_N] !== AW'((int'(base) + i) % RAM_N) ||
          wr_data_log[(w0 + i) % LOG_N] !== si_src[i]) errs++;
      ref_mem[(int'(base) + i) % RAM_N] = si_src[i];
    end
    total++;
    if (wr_cnt - w0 !== RAM_N || errs !== 0 || dn !== 1) begin
      bad++; $display("FAIL full_load: writes=%0d wrong=%0d done=%0d expected %0d 0 1", wr_cnt - w0, errs, dn, RAM_N);
    end
    base = AW'($urandom_range(0, RAM_N - 1));
    do_save(base, AW'(RAM_N - 1), 0, dn, an, pa, fa, bv, to);
    errs = 0;
    for (int i = 0; i < RAM_N && i < so_got.size(); i++)
      if (so_got[i] !== ref_mem[(int'(base) + i) % RAM_N]) errs++;
    total++;
    if (so_got.size() !== RAM_N || errs !== 0 || dn !== 1) begin
      bad++; $display("FAIL full_save: bytes=%0d wrong=%0d done=%0d expected %0d 0 1", so_got.size(), errs, dn, RAM_N);
    end
  endtask

  task automatic test_protocol();
    total++;
    if (prot_err !== 0) begin
      bad++; $display("FAIL protocol: got %0d violations expected 0", prot_err);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.CMD_START = 1'b0;
    bus.CMD_DIR  = 1'b0;
    bus.CMD_BASE = '0;
    bus.CMD_LEN  = '0;
    bus.ABORT    = 1'b0;
    bus.SI_DATA  = '0;
    bus.SI_VALID = 1'b0;
    bus.SO_READY = 1'b0;
    test_reset();
    init_ram();
    test_save_basic();
    test_load_wrap();
    test_backpressure();
    test_abort();
    test_busy_ignore();
    test_len_zero();
    test_reset_mid_save();
    test_random();
    test_full_ram();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hiscore_xfer.md
HISCORE_XFER -- requirements
Module: hiscore_xfer

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the width of the hiscore RAM address.
REQ-002 SHALL have parameter RD_LAT, default 2, the number of cycles from hs_address change to valid hs_data_out (range 1..7).
REQ-003 SHALL have parameter SETTLE, default 16, the number of cycles between PAUSE_REQ rising and the first RAM access (range 1..255).
REQ-004 SHALL have the ports below, clock and reset first:
- MCLK in 1: sole clock (48 MHz); all logic on its rising edge.
- RESET in 1: synchronous, active-high.
- CMD_START in 1: one-cycle command strobe.
- CMD_DIR in 1: 0 = save (RAM to host), 1 = load (host to RAM); sampled with CMD_START.
- CMD_BASE in ADDR_W: first RAM address; sampled with CMD_START.
- CMD_LEN in ADDR_W: byte count minus 1; sampled with CMD_START.
- ABORT in 1: cancels the active command.
- BUSY out 1: command in progress.
- DONE out 1: one-cycle pulse on normal completion.
- ABORTED out 1: one-cycle pulse on abort.
- PAUSE_REQ out 1: freezes the game CPUs; high from accept to completion or abort.
- SI_DATA in 8, SI_VALID in 1, SI_READY out 1: host-to-RAM byte stream.
- SO_DATA out 8, SO_VALID out 1, SO_READY in 1: RAM-to-host byte stream.
- hs_address out ADDR_W, hs_data_in out 8, hs_data_out in 8, hs_write out 1, hs_access out 1: game-side hiscore RAM port.

Function
REQ-005 SHALL implement states IDLE, SETTLE, RD_ADDR, RD_WAIT, RD_OUT, WR_IN, WR_STB, FINISH.
REQ-006 SHALL, in IDLE on CMD_START=1, latch CMD_DIR/BASE/LEN, raise BUSY and PAUSE_REQ next cycle, and enter SETTLE.
REQ-007 SHALL ignore CMD_START while BUSY=1.
REQ-008 SHALL stay in SETTLE exactly SETTLE cycles, then raise hs_access and go to RD_ADDR (save) or WR_IN (load).
REQ-009 SHALL, in RD_ADDR, drive hs_address = base + index, then hold RD_WAIT for RD_LAT cycles and capture hs_data_out into SO_DATA on the last of them.
REQ-010 SHALL, in RD_OUT, hold SO_VALID=1 and SO_DATA stable until SO_READY=1; the transfer completes on the cycle where both are 1.
REQ-011 SHALL, in WR_IN, assert SI_READY=1; on SI_VALID & SI_READY, latch SI_DATA into hs_data_in and go to WR_STB.
REQ-012 SHALL, in WR_STB, pulse hs_write for exactly one cycle with hs_address and hs_data_in stable during that cycle.
REQ-013 SHALL, after each byte, go to FINISH when index = LEN; otherwise increment index and return to RD_ADDR or WR_IN.
REQ-014 SHALL compute address = base + index modulo 2^ADDR_W, so addresses wrap past the top of RAM.
REQ-015 SHALL, in FINISH, pulse DONE, and on the same edge drop hs_access, PAUSE_REQ and BUSY, returning to IDLE.
REQ-016 SHALL, when ABORT=1 in any non-IDLE state, go to IDLE next cycle, pulse ABORTED, and clear BUSY, PAUSE_REQ, hs_access, hs_write, SI_READY and SO_VALID; DONE SHALL NOT pulse.
REQ-017 SHALL give ABORT priority over a simultaneous stream handshake; that byte counts as not transferred.
REQ-018 SHALL treat ABORT in IDLE as having no effect.
REQ-019 SHALL never assert hs_write while hs_access=0, and never assert SI_READY and SO_VALID together.
REQ-020 SHALL make LEN=0 transfer exactly one byte; LEN=2^ADDR_W-1 SHALL transfer every RAM byte once.

Reset
REQ-021 SHALL, on RESET=1 at a clock edge, enter IDLE and drive every output to 0 (hs_address, hs_data_in and SO_DATA all zero), including mid-command, without pulsing DONE or ABORTED.
REQ-022 SHALL have RESET take priority over ABORT and CMD_START.

Structure
REQ-023 SHALL take the state enumeration and the ADDR_W, RD_LAT and SETTLE defaults from a shared package, digdug_hs_pkg.
REQ-024 SHALL implement both SETTLE and RD_WAIT timing with one loadable down-counter sub-module, hs_delay_ctr (load value, enable, zero flag).

Verification
REQ-025 Save: BASE=0x3F0, LEN=3, SETTLE=16, SO_READY=1 -> PAUSE_REQ rises 1 cycle after start; first hs_access 16 cycles later; SO bytes = RAM[0x3F0..0x3F3]; DONE 1 pulse.
REQ-026 Load with wrap: BASE=0x7FE, LEN=3, SI bytes A1 B2 C3 D4 -> hs_write pulses at 0x7FE, 0x7FF, 0x000, 0x001 with those data; exactly 4 hs_write pulses.
REQ-027 Backpressure: save LEN=1, SO_READY low 10 cycles -> SO_VALID held, SO_DATA stable, no address advance until ready.
REQ-028 Abort: ABORT on the same cycle as the second SI handshake of a 4-byte load -> exactly 1 hs_write, ABORTED pulse, no DONE, all outputs 0 next cycle.
REQ-029 Reset mid-save in RD_WAIT -> next cycle all outputs 0; CMD_START while BUSY ignored (params unchanged).
